// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T0-T4 control unit for the 8-bit SAP CPU.
module control_sequencer #(
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic [2:0] step,
  output logic       halted,
  output logic       oe_pc,
  output logic       oe_ram,
  output logic       oe_ir,
  output logic       oe_a,
  output logic       oe_alu,
  output logic       load_mar,
  output logic       load_ir,
  output logic       load_a,
  output logic       load_b,
  output logic       load_ram,
  output logic       load_out,
  output logic       load_pc,
  output logic       load_flags,
  output logic       pc_inc,
  output logic       alu_sub
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;
  localparam logic [14:0] OE_PC  = 15'h4000, OE_RAM = 15'h2000, OE_IR  = 15'h1000,
                          OE_A   = 15'h0800, OE_ALU = 15'h0400, LD_MAR = 15'h0200,
                          LD_IR  = 15'h0100, LD_A   = 15'h0080, LD_B   = 15'h0040,
                          LD_RAM = 15'h0020, LD_OUT = 15'h0010, LD_PC  = 15'h0008,
                          LD_FL  = 15'h0004, PC_INC = 15'h0002, SUB    = 15'h0001;
  step_t       st, st_nx, last;
  logic        halt_nx;
  logic [14:0] w;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st     <= T0;
      halted <= 1'b0;
    end else begin
      st     <= st_nx;
      halted <= halt_nx;
    end
  always_comb begin
    last = T1;
    case (opcode)
      4'h1, 4'h4:                             last = T3;
      4'h2, 4'h3:                             last = T4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF:     last = T2;
      default:                                last = T1;
    endcase
    halt_nx = halted || (st == T2 && opcode == 4'hF);
    st_nx   = halt_nx ? st :
              ((EARLY_END && st == last) || st == T4) ? T0 : step_t'(st + 3'd1);
  end
  // Flags only enter the decode in T2, so changes in other steps are invisible.
  always_comb begin
    w = '0;
    case (st)
      T0: w = OE_PC | LD_MAR;
      T1: w = OE_RAM | LD_IR | PC_INC;
      T2:
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4: w = OE_IR | LD_MAR;
          4'h5:                   w = OE_IR | LD_A;
          4'h6:                   w = OE_IR | LD_PC;
          4'h7:                   w = flag_c ? (OE_IR | LD_PC) : '0;
          4'h8:                   w = flag_z ? (OE_IR | LD_PC) : '0;
          4'hE:                   w = OE_A | LD_OUT;
          default:                w = '0;
        endcase
      T3:
        case (opcode)
          4'h1:       w = OE_RAM | LD_A;
          4'h2, 4'h3: w = OE_RAM | LD_B;
          4'h4:       w = OE_A | LD_RAM;
          default:    w = '0;
        endcase
      T4: w = (opcode == 4'h2 || opcode == 4'h3) ?
              (OE_ALU | LD_A | LD_FL | ((opcode == 4'h3) ? SUB : 15'h0)) : '0;
      default: w = '0;
    endcase
  end
  assign step = st;
  assign {oe_pc, oe_ram, oe_ir, oe_a, oe_alu, load_mar, load_ir, load_a, load_b,
          load_ram, load_out, load_pc, load_flags, pc_inc, alu_sub} = (reset && !halted) ? w : '0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of control_sequencer in both EARLY_END modes.
module tb_control_sequencer;
  localparam logic [14:0] OE_PC  = 15'h4000, OE_RAM = 15'h2000, OE_IR  = 15'h1000,
                          OE_A   = 15'h0800, OE_ALU = 15'h0400, LD_MAR = 15'h0200,
                          LD_IR  = 15'h0100, LD_A   = 15'h0080, LD_B   = 15'h0040,
                          LD_RAM = 15'h0020, LD_OUT = 15'h0010, LD_PC  = 15'h0008,
                          LD_FL  = 15'h0004, PC_INC = 15'h0002, SUB    = 15'h0001;
  localparam logic [14:0] W_T0 = OE_PC | LD_MAR, W_T1 = OE_RAM | LD_IR | PC_INC;
  logic       clk, reset, reset0, flag_c, flag_z;
  logic [3:0] opcode;
  logic [2:0] st1, st0;
  logic       h1, h0;
  logic [14:0] w1, w0;
  int n_cmp = 0, n_err = 0;
  logic oe_pc1, oe_ram1, oe_ir1, oe_a1, oe_alu1, load_mar1, load_ir1, load_a1, load_b1,
        load_ram1, load_out1, load_pc1, load_flags1, pc_inc1, alu_sub1;
  logic oe_pc0, oe_ram0, oe_ir0, oe_a0, oe_alu0, load_mar0, load_ir0, load_a0, load_b0,
        load_ram0, load_out0, load_pc0, load_flags0, pc_inc0, alu_sub0;
  control_sequencer #(.EARLY_END(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .step(st1), .halted(h1), .oe_pc(oe_pc1), .oe_ram(oe_ram1), .oe_ir(oe_ir1),
    .oe_a(oe_a1), .oe_alu(oe_alu1), .load_mar(load_mar1), .load_ir(load_ir1),
    .load_a(load_a1), .load_b(load_b1), .load_ram(load_ram1), .load_out(load_out1),
    .load_pc(load_pc1), .load_flags(load_flags1), .pc_inc(pc_inc1), .alu_sub(alu_sub1));
  control_sequencer #(.EARLY_END(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .step(st0), .halted(h0), .oe_pc(oe_pc0), .oe_ram(oe_ram0), .oe_ir(oe_ir0),
    .oe_a(oe_a0), .oe_alu(oe_alu0), .load_mar(load_mar0), .load_ir(load_ir0),
    .load_a(load_a0), .load_b(load_b0), .load_ram(load_ram0), .load_out(load_out0),
    .load_pc(load_pc0), .load_flags(load_flags0), .pc_inc(pc_inc0), .alu_sub(alu_sub0));
  assign w1 = {oe_pc1, oe_ram1, oe_ir1, oe_a1, oe_alu1, load_mar1, load_ir1, load_a1, load_b1,
               load_ram1, load_out1, load_pc1, load_flags1, pc_inc1, alu_sub1};
  assign w0 = {oe_pc0, oe_ram0, oe_ir0, oe_a0, oe_alu0, load_mar0, load_ir0, load_a0, load_b0,
               load_ram0, load_out0, load_pc0, load_flags0, pc_inc0, alu_sub0};
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic cyc1(input string tag, input logic [2:0] s, input logic h, input logic [14:0] w);
    chk(tag, {st1, h1, w1}, {s, h, w});
    tick();
  endtask
  task automatic cyc0(input string tag, input logic [2:0] s, input logic h, input logic [14:0] w);
    chk(tag, {st0, h0, w0}, {s, h, w});
    tick();
  endtask
  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4:                     return 4;
      4'h2, 4'h3:                     return 5;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE:   return 3;
      default:                        return 2;
    endcase
  endfunction
  initial begin
    int n;
    reset = 1'b0; reset0 = 1'b0; opcode = 4'h2; flag_c = 1'b0; flag_z = 1'b0;
    #1;
    chk("reset_state", {st1, h1, w1}, 19'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cyc1("add_t0", 3'd0, 1'b0, W_T0);
    cyc1("add_t1", 3'd1, 1'b0, W_T1);
    cyc1("add_t2", 3'd2, 1'b0, OE_IR | LD_MAR);
    chk("add_t3", {st1, h1, w1}, {3'd3, 1'b0, OE_RAM | LD_B});
    reset = 1'b0;
    #1;
    chk("reset_mid_t3", {st1, h1, w1}, 19'h0);
    reset = 1'b1;
    #1;
    cyc1("rst_release_t0", 3'd0, 1'b0, W_T0);
    cyc1("add2_t1", 3'd1, 1'b0, W_T1);
    cyc1("add2_t2", 3'd2, 1'b0, OE_IR | LD_MAR);
    cyc1("add2_t3", 3'd3, 1'b0, OE_RAM | LD_B);
    cyc1("add2_t4", 3'd4, 1'b0, OE_ALU | LD_A | LD_FL);
    opcode = 4'h3;
    cyc1("sub_t0", 3'd0, 1'b0, W_T0);
    cyc1("sub_t1", 3'd1, 1'b0, W_T1);
    cyc1("sub_t2", 3'd2, 1'b0, OE_IR | LD_MAR);
    cyc1("sub_t3", 3'd3, 1'b0, OE_RAM | LD_B);
    cyc1("sub_t4", 3'd4, 1'b0, OE_ALU | LD_A | LD_FL | SUB);
    opcode = 4'h7; flag_c = 1'b1;
    cyc1("jc1_t0", 3'd0, 1'b0, W_T0);
    cyc1("jc1_t1", 3'd1, 1'b0, W_T1);
    cyc1("jc1_t2", 3'd2, 1'b0, OE_IR | LD_PC);
    flag_c = 1'b0;
    cyc1("jc0_t0", 3'd0, 1'b0, W_T0);
    cyc1("jc0_t1", 3'd1, 1'b0, W_T1);
    cyc1("jc0_t2", 3'd2, 1'b0, 15'h0);
    opcode = 4'h8; flag_z = 1'b1;
    cyc1("jz_late_t0", 3'd0, 1'b0, W_T0);
    cyc1("jz_late_t1", 3'd1, 1'b0, W_T1);
    flag_z = 1'b0;
    #1;
    cyc1("jz_late_t2", 3'd2, 1'b0, 15'h0);
    flag_z = 1'b1; flag_c = 1'b1;
    cyc1("jz1_t0", 3'd0, 1'b0, W_T0);
    cyc1("jz1_t1", 3'd1, 1'b0, W_T1);
    cyc1("jz1_t2", 3'd2, 1'b0, OE_IR | LD_PC);
    opcode = 4'h1;
    cyc1("lda_t0", 3'd0, 1'b0, W_T0);
    cyc1("lda_t1", 3'd1, 1'b0, W_T1);
    cyc1("lda_t2", 3'd2, 1'b0, OE_IR | LD_MAR);
    cyc1("lda_t3", 3'd3, 1'b0, OE_RAM | LD_A);
    opcode = 4'h4;
    cyc1("sta_t0", 3'd0, 1'b0, W_T0);
    cyc1("sta_t1", 3'd1, 1'b0, W_T1);
    cyc1("sta_t2", 3'd2, 1'b0, OE_IR | LD_MAR);
    cyc1("sta_t3", 3'd3, 1'b0, OE_A | LD_RAM);
    opcode = 4'h5;
    cyc1("ldi_t0", 3'd0, 1'b0, W_T0);
    cyc1("ldi_t1", 3'd1, 1'b0, W_T1);
    cyc1("ldi_t2", 3'd2, 1'b0, OE_IR | LD_A);
    opcode = 4'h6;
    cyc1("jmp_t0", 3'd0, 1'b0, W_T0);
    cyc1("jmp_t1", 3'd1, 1'b0, W_T1);
    cyc1("jmp_t2", 3'd2, 1'b0, OE_IR | LD_PC);
    opcode = 4'hE;
    cyc1("out_t0", 3'd0, 1'b0, W_T0);
    cyc1("out_t1", 3'd1, 1'b0, W_T1);
    cyc1("out_t2", 3'd2, 1'b0, OE_A | LD_OUT);
    opcode = 4'h0;
    cyc1("nop_t0", 3'd0, 1'b0, W_T0);
    cyc1("nop_t1", 3'd1, 1'b0, W_T1);
    opcode = 4'hB;
    cyc1("nopb_t0", 3'd0, 1'b0, W_T0);
    cyc1("nopb_t1", 3'd1, 1'b0, W_T1);
    opcode = 4'hF;
    cyc1("hlt_t0", 3'd0, 1'b0, W_T0);
    cyc1("hlt_t1", 3'd1, 1'b0, W_T1);
    cyc1("hlt_t2", 3'd2, 1'b0, 15'h0);
    for (int i = 0; i < 21; i++) cyc1($sformatf("halted_%0d", i), 3'd2, 1'b1, 15'h0);
    reset = 1'b0;
    #1;
    chk("halt_reset", {st1, h1, w1}, 19'h0);
    reset = 1'b1;
    #1;
    chk("halt_release", {st1, h1, w1}, {3'd0, 1'b0, W_T0});
    chk("ee0_reset", {st0, h0, w0}, 19'h0);
    reset0 = 1'b1; opcode = 4'h5;
    #1;
    cyc0("ee0_ldi_t0", 3'd0, 1'b0, W_T0);
    cyc0("ee0_ldi_t1", 3'd1, 1'b0, W_T1);
    cyc0("ee0_ldi_t2", 3'd2, 1'b0, OE_IR | LD_A);
    cyc0("ee0_ldi_t3", 3'd3, 1'b0, 15'h0);
    cyc0("ee0_ldi_t4", 3'd4, 1'b0, 15'h0);
    opcode = 4'h0;
    cyc0("ee0_nop_t0", 3'd0, 1'b0, W_T0);
    cyc0("ee0_nop_t1", 3'd1, 1'b0, W_T1);
    cyc0("ee0_nop_t2", 3'd2, 1'b0, 15'h0);
    cyc0("ee0_nop_t3", 3'd3, 1'b0, 15'h0);
    cyc0("ee0_nop_t4", 3'd4, 1'b0, 15'h0);
    chk("ee0_wrap", {st0, h0, w0}, {3'd0, 1'b0, W_T0});
    reset = 1'b0; reset0 = 1'b0;
    tick();
    reset = 1'b1; reset0 = 1'b1;
    #1;
    for (int i = 0; i < 1000; i++) begin
      opcode = 4'($urandom_range(0, 14));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      #1;
      n = 0;
      do begin
        chk($sformatf("rand%0d_bus1", i), 19'($countones(w1[14:10]) <= 1), 19'd1);
        chk($sformatf("rand%0d_bus0", i), 19'($countones(w0[14:10]) <= 1), 19'd1);
        tick();
        n++;
      end while (st1 != 3'd0 && n < 8);
      chk($sformatf("rand%0d_len_op%0h", i, opcode), 19'(n), 19'(ilen(opcode)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
